uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive front-end feeding the Controller command path: takes the raw `rx` pin, deserialises 8N1 UART frames and buffers the received bytes in a small FIFO.
- The Controller pops bytes through a first-word-fall-through read interface.
- The block is clocked by the same board clock as the Controller (`clk`, or the divided `clk_o` in HIGH_CLK builds).

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BIT_RATE, 115200, UART bit rate in baud.
- PAYLOAD_BITS, 8, data bits per frame.
- BUFFER_SIZE, 8, FIFO depth in entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; asynchronous to clk; idle level is high.
- read  in  1  pop strobe; pops the head entry when empty=0, ignored when empty=1.
- read_data  out  PAYLOAD_BITS  head entry; valid while empty=0.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds BUFFER_SIZE entries.
- count  out  $clog2(BUFFER_SIZE+1)  current number of entries.
- frame_error  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- overflow  out  1  one-cycle pulse: byte received while full, byte discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both synchroniser flops go to 1; FSM goes to IDLE; FIFO pointers and count go to 0.
  - Output values: empty=1, full=0, count=0, read_data=0, frame_error=0, overflow=0.
  - Reset mid-frame discards the partial byte.
- Bit timing:
  - CPB = CLK_FREQ/BIT_RATE, integer division; CPB must be at least 4.
  - A bit counter of width $clog2(CPB) cycles through the bit period.
- Synchronisation: rx passes through a two-flop synchroniser to give rx_s; every decision uses rx_s.
- FSM transitions:
  - IDLE: rx_s=0 with the previous rx_s=1 (a falling edge) -> START, counter cleared.
  - START: when counter = CPB/2-1, sample rx_s.
    - rx_s=1 -> IDLE (glitch rejected, nothing reported).
    - rx_s=0 -> DATA, counter cleared, bit index = 0.
  - DATA: every CPB cycles, sample rx_s into shift register bit [index], LSB first. After bit PAYLOAD_BITS-1 -> STOP.
  - STOP: after CPB cycles, sample rx_s.
    - rx_s=1 -> push the byte, return to IDLE.
    - rx_s=0 -> pulse frame_error, drop the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then -> IDLE. A line held low (break) does not retrigger START.
- Push:
  - The write occurs on the clock edge that samples the stop bit.
  - empty, count and read_data reflect the new entry in the next cycle.
  - From the rx falling edge at the pin to empty=0 takes 2 + CPB/2 + PAYLOAD_BITS*CPB + CPB + 1 cycles, ±1.
- FIFO:
  - Circular buffer with a write pointer, a read pointer and an explicit count; pointers wrap modulo BUFFER_SIZE.
  - read_data = mem[rd_ptr] (first-word fall-through).
  - A pop takes effect on the clock edge where read=1 and empty=0; the next entry appears the following cycle.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen and count is unchanged.
  - full=1: the pop frees a slot, the push is accepted and overflow stays 0.
  - empty=1: only the push happens and read is ignored.
- Push while full without read: the byte is dropped, overflow pulses for exactly 1 cycle and FIFO contents are unchanged.
- A framing-error byte never enters the FIFO.
- full and empty are derived from count: full = (count == BUFFER_SIZE), empty = (count == 0).

Test Plan:
- Bench settings: CLK_FREQ=1000000, BIT_RATE=100000 (CPB=10), BUFFER_SIZE=8.
1. Reset, then send 0xA5 (8N1) -> empty falls within 97-99 cycles of the start edge; read_data=0xA5; count=1; pulse read -> empty=1, count=0.
2. Low glitch of 3 cycles on rx with the line otherwise idle -> no push, frame_error=0, empty stays 1, FSM back in IDLE.
3. Send 0x3C with the stop bit forced low, then rx held low for 30 cycles, then a valid 0x81 -> exactly one frame_error pulse; FIFO contains only 0x81.
4. Send 0x00..0x08 back-to-back with no reads -> full=1 after 0x07, count=8; overflow pulses once on 0x08; reading 8 times returns 0x00..0x07 in order, then empty=1.
5. FIFO full; assert read on the exact cycle 0x55 is pushed -> overflow=0, count stays 8; after the pop the last entry read out is 0x55 (pointer wrap exercised).
6. Assert reset=0 in the middle of the DATA bits of 0xF0, release it, then send 0x12 -> the partial byte is lost; FIFO holds only 0x12; all outputs at reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through FIFO for the Controller command path.
// rx is synchronised, frames are mid-bit sampled, and good bytes are queued for popping.
module uart_rx_fifo #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   rx,
    input  logic                                   read,
    output logic [PAYLOAD_BITS-1:0]                read_data,
    output logic                                   empty,
    output logic                                   full,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]       count,
    output logic                                   frame_error,
    output logic                                   overflow
);

    localparam int CPB   = CLK_FREQ / BIT_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CW    = $clog2(BUFFER_SIZE + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic                    sync1_q, sync2_q, rx_prev_q;
    logic                    rx_s;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overflow_q, overflow_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PAYLOAD_BITS-1:0] mem_q [BUFFER_SIZE];
    logic                    push, pop, wr_en;

    assign rx_s = sync2_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s && rx_prev_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A held-low line must return high before a new start edge counts.
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop on the same edge frees the slot, so a push while full is still accepted.
    always_comb begin
        pop        = read && (count_q != '0);
        wr_en      = push && ((count_q != CNT_FULL) || pop);
        overflow_d = push && (count_q == CNT_FULL) && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sync1_q       <= rx;
            sync2_q       <= sync1_q;
            rx_prev_q     <= sync2_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Storage is not reset, so the head is forced to zero whenever nothing is queued.
    assign read_data   = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_FULL);
    assign count       = count_q;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks every pop.
module tb_uart_rx_fifo;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       read;
   logic [7:0] read_data;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       frame_error;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int frameErrPulses = 0;
   int overflowPulses = 0;
   bit [7:0] expQ[$];

   uart_rx_fifo #(
      .CLK_FREQ(1000000),
      .BIT_RATE(100000),
      .PAYLOAD_BITS(8),
      .BUFFER_SIZE(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx(rx),
      .read(read),
      .read_data(read_data),
      .empty(empty),
      .full(full),
      .count(count),
      .frame_error(frame_error),
      .overflow(overflow)
   );

   // Free-running 100 MHz bench clock; inputs change 1 ns after each rising edge.
   always #5 clk = ~clk;

   // Monitor: on the falling edge, tally error pulses and check every byte that will pop.
   always @(negedge clk) begin
      if (reset) begin
         if (frame_error) frameErrPulses++;
         if (overflow) overflowPulses++;
         if (read && !empty) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL pop_unexpected: got %02h, scoreboard holds nothing", read_data);
            end else begin
               bit [7:0] expByte;
               expByte = expQ.pop_front();
               if (read_data !== expByte) begin
                  errors++;
                  $display("[TB] FAIL pop_data: got %02h expected %02h", read_data, expByte);
               end
            end
         end
      end
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Hold rx at a level for n clock cycles; called 1 ns after a rising edge.
   task automatic driveRx(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendFrame(input bit [7:0] data, input logic stopBit);
      driveRx(1'b0, CPB);
      for (int i = 0; i < 8; i++) driveRx(data[i], CPB);
      driveRx(stopBit, CPB);
   endtask

   // Queue the expected byte (when it should be stored) and transmit the frame.
   task automatic applyStimulus(input bit [7:0] data, input logic stopBit, input bit expectPush);
      if (expectPush) expQ.push_back(data);
      sendFrame(data, stopBit);
   endtask

   task automatic popOne();
      read = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_empty"}, empty, 1);
      checkOutput({tag, "_full"}, full, 0);
      checkOutput({tag, "_count"}, count, 0);
      checkOutput({tag, "_read_data"}, read_data, 0);
      checkOutput({tag, "_frame_error"}, frame_error, 0);
      checkOutput({tag, "_overflow"}, overflow, 0);
   endtask

   // Main directed sequence.
   initial begin
      int lat;
      int fe0;
      int ov0;
      reset = 1'b0;
      rx    = 1'b1;
      read  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b1;
      driveRx(1'b1, 5);

      $display("[TB] test 1: single byte 0xA5 and latency");
      lat = 0;
      fork
         applyStimulus(8'hA5, 1'b1, 1'b1);
         begin
            while (empty && lat < 200) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      checks++;
      if (lat < 97 || lat > 99) begin
         errors++;
         $display("[TB] FAIL t1_latency: got %0d cycles expected 97..99", lat);
      end
      checkOutput("t1_count", count, 1);
      checkOutput("t1_head", read_data, 8'hA5);
      popOne();
      checkOutput("t1_empty_after_pop", empty, 1);
      checkOutput("t1_count_after_pop", count, 0);

      $display("[TB] test 2: 3-cycle glitch");
      fe0 = frameErrPulses;
      driveRx(1'b0, 3);
      driveRx(1'b1, 30);
      checkOutput("t2_empty", empty, 1);
      checkOutput("t2_no_frame_error", frameErrPulses - fe0, 0);

      $display("[TB] test 3: framing error then break then 0x81");
      fe0 = frameErrPulses;
      applyStimulus(8'h3C, 1'b0, 1'b0);
      driveRx(1'b0, 30);
      driveRx(1'b1, 5);
      applyStimulus(8'h81, 1'b1, 1'b1);
      driveRx(1'b1, 3);
      checkOutput("t3_frame_error_pulses", frameErrPulses - fe0, 1);
      checkOutput("t3_count", count, 1);
      popOne();
      checkOutput("t3_empty", empty, 1);

      $display("[TB] test 4: fill to full and overflow");
      ov0 = overflowPulses;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'(i), 1'b1, i < 8);
         if (i == 6) checkOutput("t4_not_full_at_7", full, 0);
         if (i == 7) begin
            checkOutput("t4_full", full, 1);
            checkOutput("t4_count_full", count, 8);
         end
      end
      driveRx(1'b1, 3);
      checkOutput("t4_overflow_pulses", overflowPulses - ov0, 1);
      checkOutput("t4_count_after_overflow", count, 8);
      checkOutput("t4_head_unchanged", read_data, 8'h00);
      repeat (8) popOne();
      checkOutput("t4_empty", empty, 1);

      $display("[TB] test 5: push and pop on the same edge while full");
      for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b1);
      checkOutput("t5_full", full, 1);
      ov0 = overflowPulses;
      expQ.push_back(8'h55);
      fork
         sendFrame(8'h55, 1'b1);
         begin
            repeat (97) @(posedge clk);
            #1;
            read = 1'b1;
            @(posedge clk);
            #1;
            read = 1'b0;
         end
      join
      driveRx(1'b1, 3);
      checkOutput("t5_no_overflow", overflowPulses - ov0, 0);
      checkOutput("t5_count", count, 8);
      repeat (8) popOne();
      checkOutput("t5_empty", empty, 1);

      $display("[TB] test 6: reset during DATA bits");
      applyStimulus(8'h99, 1'b1, 1'b1);
      driveRx(1'b1, 3);
      checkOutput("t6_count_before", count, 1);
      driveRx(1'b0, CPB);
      driveRx(1'b0, 2 * CPB);
      reset = 1'b0;
      rx    = 1'b1;
      #1;
      checkResetValues("t6_async");
      expQ.delete();
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("t6_held");
      reset = 1'b1;
      driveRx(1'b1, 5);
      applyStimulus(8'h12, 1'b1, 1'b1);
      driveRx(1'b1, 3);
      checkOutput("t6_count", count, 1);
      popOne();
      checkOutput("t6_empty", empty, 1);

      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
